stream_in_feeder: RTL and testbench
===================================

STREAM_IN_FEEDER -- requirements
Module: stream_in_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the data path on both sides.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the length and token counters.
REQ-003 SHALL have port clock, in, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, in, 1: one-cycle job start request.
REQ-006 SHALL have port length, in, CNT_WIDTH: tokens in the job, sampled only on an accepted start.
REQ-007 SHALL have port in_data, in, DATA_WIDTH: upstream streamer data.
REQ-008 SHALL have port in_valid, in, 1: upstream data valid.
REQ-009 SHALL have port in_ready, out, 1: feeder can accept in_data this cycle.
REQ-010 SHALL have port out_data, out, DATA_WIDTH: drives the dataflow network's inStream0_data.
REQ-011 SHALL have port out_wr, out, 1: drives inStream0_wr.
REQ-012 SHALL have port out_full, in, 1: from inStream0_full; out_wr is never asserted while it is high.
REQ-013 SHALL have port busy, out, 1: job in progress.
REQ-014 SHALL have port done, out, 1: one-cycle pulse at job end.
REQ-015 SHALL have port tokens_sent, out, CNT_WIDTH: tokens delivered downstream in the current or last job.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 SHALL move IDLE->RUN on start, latch length, and clear the accept and send counters; with length==0, IDLE->DONE instead.
REQ-018 SHALL ignore start in any state other than IDLE.
REQ-019 SHALL count an upstream transfer when in_valid && in_ready, and a downstream transfer when out_wr, which implies !out_full.
REQ-020 SHALL use a 2-entry FIFO (skid buffer) between the sides; in_ready = (state==RUN) && (accepted<length) && (entries<2), registered-state only, with no combinational path from out_full.
REQ-021 SHALL drive out_wr = (entries>0) && !out_full; out_data = head entry.
REQ-022 SHALL present a token accepted in cycle N on out_data/out_wr no earlier than cycle N+1.
REQ-023 SHALL handle a simultaneous push and pop in one cycle: occupancy unchanged, order preserved.
REQ-024 SHALL move RUN->DRAIN when accepted reaches length, and DRAIN->DONE when sent reaches length; both may complete in the same cycle, going RUN->DONE directly.
REQ-025 SHALL assert done for exactly one cycle, the cycle in DONE, then return to IDLE.
REQ-026 SHALL keep busy high in RUN and DRAIN, and low in IDLE and DONE.
REQ-027 SHALL hold tokens_sent after DONE until the next accepted start.
REQ-028 SHALL stall indefinitely under sustained out_full with no data loss and no spurious out_wr.
REQ-029 SHALL sustain 1 token/cycle when in_valid is high and out_full is low.

Reset
REQ-030 SHALL, on reset low: state=IDLE; FIFO empty; counters and latched length=0; in_ready=0, out_wr=0, busy=0, done=0, tokens_sent=0; out_data=0.
REQ-031 SHALL, on reset asserted mid-job, abandon the job immediately: discard buffered tokens, emit no done pulse.

Structure
REQ-032 SHALL place the FSM state encoding and the FIFO depth constant (2) in the shared package stream_feeder_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module stream_skid_fifo, with push/pop/full/empty ports and DATA_WIDTH.

Verification
REQ-034 SHALL cover basic job: length=4, in_valid steady, out_full=0 -> 4 out_wr pulses in 4 consecutive cycles starting one cycle after the first accept; done one cycle after the last; tokens_sent=4.
REQ-035 SHALL cover backpressure: length=8, out_full high for cycles 3-10 -> in_ready drops after 2 buffered tokens, no out_wr while full, data order 0..7 intact, done after the 8th send.
REQ-036 SHALL cover zero length: start with length=0 -> done pulses the next cycle, busy never high, in_ready never high.
REQ-037 SHALL cover start while busy: second start with length=99 during a length=5 job -> ignored; exactly 5 tokens sent.
REQ-038 SHALL cover mid-job reset: reset low after 3 of 6 tokens -> all outputs 0 asynchronously; no done; a new length=2 job then completes normally.
REQ-039 SHALL cover bubbly input: length=6, in_valid toggling 1/0 -> 6 tokens in order, no duplicates.

Source files
------------

// File: rtl/stream_feeder_pkg.sv
// Shared types and constants for the stream input feeder and its skid buffer.
package stream_feeder_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid buffer decoupling the upstream handshake from downstream backpressure.
module stream_skid_fifo
    import stream_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;

    // Storage and pointers; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + FIFO_PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/stream_in_feeder.sv
// Feeds a fixed-length job of upstream tokens into a dataflow input stream,
// honouring the downstream full flag through a two-entry skid buffer.
module stream_in_feeder
    import stream_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wr,
    input  logic                  out_full,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  tokens_sent
);

    feeder_state_e        r_state;
    feeder_state_e        w_next_state;
    logic [CNT_WIDTH-1:0] r_length;
    logic [CNT_WIDTH-1:0] r_accepted;
    logic [CNT_WIDTH-1:0] r_sent;
    logic [CNT_WIDTH-1:0] w_accepted_next;
    logic [CNT_WIDTH-1:0] w_sent_next;
    logic                 w_start_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    assign w_start_ok      = (r_state == ST_IDLE) && start;
    assign w_push          = in_valid && in_ready;
    assign w_pop           = out_wr;
    assign w_accepted_next = r_accepted + CNT_WIDTH'(w_push);
    assign w_sent_next     = r_sent + CNT_WIDTH'(w_pop);

    stream_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transitions look at next-cycle counts so the last transfer retires the phase at once.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (length == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_sent_next == r_length) begin
                    w_next_state = ST_DONE;
                end else if (w_accepted_next == r_length) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_sent_next == r_length) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Decoded from registered state only; out_full never reaches in_ready.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = (r_accepted < r_length) && !w_fifo_full;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Job length and transfer counters; sent count stays visible until the next start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_length   <= '0;
            r_accepted <= '0;
            r_sent     <= '0;
        end else if (w_start_ok) begin
            r_length   <= length;
            r_accepted <= '0;
            r_sent     <= '0;
        end else begin
            r_accepted <= w_accepted_next;
            r_sent     <= w_sent_next;
        end
    end

    assign out_wr      = !w_fifo_empty && !out_full;
    assign tokens_sent = r_sent;

endmodule

// File: tb/tb_stream_in_feeder.sv
// Self-checking bench for stream_in_feeder against a job-level behavioural model.
module tb_stream_in_feeder;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] length;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_wr;
    logic          out_full;
    logic          busy;
    logic          done;
    logic [CW-1:0] tokens_sent;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: job phase flags, transfer counts and expected token order.
    bit          m_active;
    bit          m_done;
    int unsigned m_len;
    int unsigned m_acc;
    int unsigned m_sent;
    logic [DW-1:0] m_q[$];

    always #5 clock = ~clock;

    stream_in_feeder #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .length      (length),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_wr      (out_wr),
        .out_full    (out_full),
        .busy        (busy),
        .done        (done),
        .tokens_sent (tokens_sent)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_len    = 0;
        m_acc    = 0;
        m_sent   = 0;
        m_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_out_wr"}, 64'(out_wr), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_tokens_sent"}, 64'(tokens_sent), 64'(0));
        chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same point of the next cycle.
    task automatic cyc(input logic st, input logic [CW-1:0] ln, input logic v,
                       input logic f, input bit rnd);
        int unsigned buffered;
        logic        exp_rdy;
        logic        exp_wr;
        bit          idle;
        start    = st;
        length   = ln;
        in_valid = v;
        out_full = f;
        in_data  = rnd ? DW'($urandom) : DW'(m_acc);
        #3;
        buffered = m_acc - m_sent;
        exp_rdy  = m_active && (m_acc < m_len) && (buffered < 2);
        exp_wr   = (buffered > 0) && !f;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_wr", 64'(out_wr), 64'(exp_wr));
        chk("busy", 64'(busy), 64'(m_active));
        chk("done", 64'(done), 64'(m_done));
        chk("tokens_sent", 64'(tokens_sent), 64'(m_sent));
        if (exp_wr) begin
            chk("out_data", 64'(out_data), 64'(m_q[0]));
        end
        idle   = !m_active && !m_done;
        m_done = 1'b0;
        if (v && exp_rdy) begin
            m_q.push_back(in_data);
            m_acc++;
        end
        if (exp_wr) begin
            void'(m_q.pop_front());
            m_sent++;
        end
        if (m_active && m_sent == m_len) begin
            m_active = 1'b0;
            m_done   = 1'b1;
        end
        if (idle && st) begin
            m_len  = int'(ln);
            m_acc  = 0;
            m_sent = 0;
            if (ln == '0) m_done = 1'b1;
            else          m_active = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        start    = 1'b0;
        in_valid = 1'b0;
        out_full = 1'b0;
        reset    = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // vmode: 0 steady, 1 toggling, 2 random; fmode: 0 never full, 1 window [fa,fb], 2 random.
    task automatic run_job(input int unsigned len, input int vmode, input int fmode,
                           input int unsigned fa, input int unsigned fb, input bit rnd,
                           input int unsigned start2_at, input logic [CW-1:0] start2_len,
                           input int unsigned rst_at_sent);
        int unsigned k;
        logic        v;
        logic        f;
        cyc(1'b1, CW'(len), 1'b0, 1'b0, rnd);
        k = 1;
        while ((m_active || m_done) && k < 400) begin
            if (rst_at_sent != 0 && m_sent == rst_at_sent) begin
                do_reset();
                return;
            end
            if (vmode == 0)      v = 1'b1;
            else if (vmode == 1) v = (k % 2 == 1);
            else                 v = ($urandom_range(0, 3) != 0);
            if (fmode == 1)      f = (k >= fa && k <= fb);
            else if (fmode == 2) f = ($urandom_range(0, 9) < 3);
            else                 f = 1'b0;
            cyc(start2_at == k, start2_len, v, f, rnd);
            k++;
        end
        chk("job_completes_in_budget", 64'(k < 400), 64'(1));
        chk("tokens_sent_held", 64'(tokens_sent), 64'(len));
        cyc(1'b0, '0, 1'b1, 1'b0, rnd);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        length   = '0;
        in_data  = '0;
        in_valid = 1'b0;
        out_full = 1'b0;
        model_clear();
        #2;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        run_job(4, 0, 0, 0, 0, 1'b0, 0, '0, 0);
        run_job(8, 0, 1, 3, 10, 1'b0, 0, '0, 0);
        run_job(0, 0, 0, 0, 0, 1'b0, 0, '0, 0);
        run_job(5, 0, 0, 0, 0, 1'b0, 2, CW'(99), 0);
        run_job(6, 0, 0, 0, 0, 1'b0, 0, '0, 3);
        run_job(2, 0, 0, 0, 0, 1'b0, 0, '0, 0);
        run_job(6, 1, 0, 0, 0, 1'b0, 0, '0, 0);
        run_job(1, 0, 1, 1, 4, 1'b1, 0, '0, 0);

        for (int j = 0; j < 25; j++) begin
            run_job($urandom_range(0, 12), 2, 2, 0, 0, 1'b1,
                    $urandom_range(0, 8), CW'($urandom_range(1, 50)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
